sequenciador_programa: RTL and testbench

Program feeder sitting directly upstream of the multicycle processor. It holds a small writable program memory and drives the processor's DIN and Run inputs, then waits for Done before issuing the next instruction. For mvi it presents the immediate word on DIN in the cycle after issue. It also stops on a halt opcode, supports a stop request, and flags a watchdog timeout when Done never arrives.

---
 rtl/sequenciador_programa_pkg.sv | 25 ++
 rtl/sequenciador_programa_memoria.sv | 24 ++
 rtl/sequenciador_programa.sv | 143 ++++++++++++++
 tb/tb_sequenciador_programa.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_programa_pkg.sv
// Shared definitions for the program feeder: opcode field, opcode values, FSM encoding.
package sequenciador_programa_pkg;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;
    localparam logic [2:0] OPC_HLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HALT,
        ST_ERROR
    } estado_t;

    function automatic logic [2:0] opcode_of(input logic [OPC_MSB:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/sequenciador_programa_memoria.sv
// Program memory: 2^ADDR_W x DATA_W, synchronous write, asynchronous read, not reset.
module memoria_programa #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sequenciador_programa.sv
// Program feeder for the multicycle processor: issues words on DIN/Run, waits for Done.
//   state    | meaning
//   IDLE     | stopped, memory loadable, waiting for Start
//   ISSUE    | Run pulse for the word on DIN (HLT is consumed, not issued)
//   WAIT     | waiting for Done, watchdog running
//   HALT     | HLT opcode reached
//   ERROR    | watchdog expired without Done
module sequenciador_programa
    import sequenciador_programa_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [15:0]       InstrCount
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    estado_t           state_q, state_d;
    logic [DATA_W-1:0] din_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic [15:0]       count_d;
    logic              stop_q, stop_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              mem_we;
    logic [2:0]        opcode;

    assign opcode = opcode_of(DIN[OPC_MSB:0]);

    memoria_programa #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .Clock(Clock),
        .we   (mem_we),
        .waddr(LoadAddr),
        .wdata(LoadData),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            DIN        <= '0;
            PC         <= '0;
            InstrCount <= '0;
            stop_q     <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            DIN        <= din_d;
            PC         <= pc_d;
            InstrCount <= count_d;
            stop_q     <= stop_d;
            wd_q       <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        din_d   = DIN;
        pc_d    = PC;
        count_d = InstrCount;
        stop_d  = stop_q;
        wd_d    = wd_q;
        mem_we  = 1'b0;
        raddr   = '0;
        Run     = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                if (LoadEn) begin
                    mem_we = 1'b1;
                end else if (Start) begin
                    din_d   = rdata;
                    pc_d    = '0;
                    count_d = '0;
                    stop_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                raddr = PC + ADDR_W'(1);
                wd_d  = '0;
                if (Stop) stop_d = 1'b1;
                if (opcode == OPC_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    Run     = 1'b1;
                    state_d = ST_WAIT;
                    if (opcode == OPC_MVI) begin
                        din_d = rdata;
                        pc_d  = PC + ADDR_W'(2);
                    end else begin
                        pc_d = PC + ADDR_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                raddr = PC;
                wd_d  = wd_q + WD_W'(1);
                if (Stop) stop_d = 1'b1;
                if (Done) begin
                    count_d = InstrCount + 16'd1;
                    if (stop_q || Stop) begin
                        stop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        din_d   = rdata;
                        state_d = ST_ISSUE;
                    end
                // the ISSUE cycle counts toward the budget: Error lands TIMEOUT cycles after Run
                end else if (wd_d == WD_W'(TIMEOUT - 1)) begin
                    din_d   = '0;
                    state_d = ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign Halted = (state_q == ST_HALT);
    assign Error  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_sequenciador_programa.sv
// Self-checking bench: scoreboard of expected issued words, simple processor Done model.
module tb_sequenciador_programa;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;
    localparam int DEPTH   = 2**ADDR_W;

    logic              Clock = 1'b0;
    logic              Reset, Start, Stop, LoadEn, Done;
    logic [ADDR_W-1:0] LoadAddr;
    logic [DATA_W-1:0] LoadData;
    logic [DATA_W-1:0] DIN;
    logic              Run, Busy, Halted, Error;
    logic [ADDR_W-1:0] PC;
    logic [15:0]       InstrCount;

    sequenciador_programa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done),
        .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted),
        .Error(Error), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] tb_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    int  cyc = 0;
    int  last_run_cyc = -1;
    int  err_cyc = -1;
    bit  err_prev = 0;
    bit  imm_pending = 0;
    logic [DATA_W-1:0] imm_exp;
    bit  proc_en = 0;
    int  lat = 2;
    int  busy_cnt = 0;
    int  done_cyc = -1;
    bit  after_done = 0;

    // Monitor/scoreboard, then processor model, all on the falling edge.
    always @(negedge Clock) begin
        logic [DATA_W-1:0] w;
        cyc++;
        if (Error === 1'b1 && !err_prev) err_cyc = cyc;
        err_prev = (Error === 1'b1);
        if (imm_pending) begin
            imm_pending = 0;
            total++;
            if (DIN !== imm_exp) begin
                bad++;
                $display("FAIL mvi_immediate: DIN=%h want %h", DIN, imm_exp);
            end
        end
        if (Run === 1'b1) begin
            last_run_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_run: DIN=%h, no issue expected", DIN);
            end else begin
                w = exp_q.pop_front();
                if (DIN !== w) begin
                    bad++;
                    $display("FAIL issue_din: DIN=%h want %h", DIN, w);
                end
                if (w[8:6] == 3'b001 && exp_q.size() > 0) begin
                    imm_exp = exp_q.pop_front();
                    imm_pending = 1;
                end
            end
            if (after_done) begin
                after_done = 0;
                total++;
                if (cyc != done_cyc + 1) begin
                    bad++;
                    $display("FAIL run_spacing: Run at cycle %0d want %0d", cyc, done_cyc + 1);
                end
            end
        end
        if (proc_en) begin
            if (Done) Done = 1'b0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    Done = 1'b1;
                    done_cyc = cyc;
                    after_done = 1;
                end
            end
            if (Run === 1'b1) busy_cnt = lat;
        end
    end

    task automatic plan(input int max_instr);
        int pc = 0;
        int n = 0;
        logic [DATA_W-1:0] w;
        while (n < max_instr) begin
            w = tb_mem[pc];
            if (w[8:6] == 3'b111) break;
            exp_q.push_back(w);
            n++;
            if (w[8:6] == 3'b001) begin
                exp_q.push_back(tb_mem[(pc + 1) % DEPTH]);
                pc = (pc + 2) % DEPTH;
            end else begin
                pc = (pc + 1) % DEPTH;
            end
        end
    endtask

    task automatic load(input int a, input logic [DATA_W-1:0] d);
        @(negedge Clock);
        LoadEn = 1'b1; LoadAddr = ADDR_W'(a); LoadData = d;
        tb_mem[a] = d;
        @(negedge Clock);
        LoadEn = 1'b0;
    endtask

    task automatic pulse_start(input int max_instr);
        plan(max_instr);
        after_done = 0;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // which: 0 = Halted, 1 = Error, 2 = idle
    task automatic wait_for(input int which, input int bound, input string name);
        bit ok = 0;
        for (int n = 0; n < bound && !ok; n++) begin
            @(negedge Clock);
            case (which)
                0: ok = (Halted === 1'b1);
                1: ok = (Error === 1'b1);
                default: ok = (Busy === 1'b0 && Halted === 1'b0 && Error === 1'b0);
            endcase
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s: condition not reached within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        total++; if (DIN !== 16'h0) begin bad++; $display("FAIL reset_din: %h want 0000", DIN); end
        total++; if (Run !== 1'b0) begin bad++; $display("FAIL reset_run: %b want 0", Run); end
        total++; if (PC !== 5'd0) begin bad++; $display("FAIL reset_pc: %0d want 0", PC); end
        total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL reset_count: %0d want 0", InstrCount); end
        total++; if ({Busy, Halted, Error} !== 3'b000) begin bad++; $display("FAIL reset_flags: %b want 000", {Busy, Halted, Error}); end
        Reset = 1'b0;
    endtask

    task automatic test_mvi_halt;
        load(0, 16'h0040); load(1, 16'h0005); load(2, 16'h01C0);
        proc_en = 1; lat = 2;
        pulse_start(100);
        wait_for(0, 50, "t1_halt");
        total++; if (PC !== 5'd2) begin bad++; $display("FAIL t1_pc: %0d want 2", PC); end
        total++; if (InstrCount !== 16'd1) begin bad++; $display("FAIL t1_count: %0d want 1", InstrCount); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL t1_busy: %b want 0", Busy); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t1_pending: %0d issues missing, want 0", exp_q.size()); end
    endtask

    task automatic test_add_chain;
        load(0, 16'h0080); load(1, 16'h0081); load(2, 16'h0082); load(3, 16'h01C0);
        proc_en = 1; lat = 2;
        pulse_start(100);
        wait_for(0, 60, "t2_halt");
        total++; if (InstrCount !== 16'd3) begin bad++; $display("FAIL t2_count: %0d want 3", InstrCount); end
        total++; if (PC !== 5'd3) begin bad++; $display("FAIL t2_pc: %0d want 3", PC); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t2_pending: %0d issues missing, want 0", exp_q.size()); end
        proc_en = 0;
        @(negedge Clock); Done = 1'b1;
        @(negedge Clock); Done = 1'b0;
        @(negedge Clock);
        total++; if (InstrCount !== 16'd3) begin bad++; $display("FAIL t2_done_outside_wait: %0d want 3", InstrCount); end
        total++; if (Halted !== 1'b1) begin bad++; $display("FAIL t2_still_halted: %b want 1", Halted); end
    endtask

    task automatic test_timeout;
        load(0, 16'h0080); load(1, 16'h01C0);
        proc_en = 0; Done = 1'b0; busy_cnt = 0;
        pulse_start(1);
        wait_for(1, 40, "t3_error");
        @(negedge Clock);
        total++; if (err_cyc - last_run_cyc != TIMEOUT) begin bad++; $display("FAIL t3_error_delay: %0d cycles want %0d", err_cyc - last_run_cyc, TIMEOUT); end
        total++; if (DIN !== 16'h0) begin bad++; $display("FAIL t3_din: %h want 0000", DIN); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL t3_busy: %b want 0", Busy); end
        total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL t3_count: %0d want 0", InstrCount); end
        // Done on the last cycle before the timeout boundary must win
        proc_en = 1; lat = TIMEOUT - 1;
        pulse_start(100);
        wait_for(0, 60, "t3_reissue_halt");
        total++; if (Error !== 1'b0) begin bad++; $display("FAIL t3_done_wins: Error=%b want 0", Error); end
        total++; if (InstrCount !== 16'd1) begin bad++; $display("FAIL t3_reissue_count: %0d want 1", InstrCount); end
    endtask

    task automatic test_stop;
        load(0, 16'h0080); load(1, 16'h0081); load(2, 16'h01C0);
        proc_en = 1; lat = 4;
        pulse_start(1);
        @(negedge Clock); Stop = 1'b1;
        @(negedge Clock); Stop = 1'b0;
        wait_for(2, 30, "t4_idle");
        repeat (8) @(negedge Clock);
        total++; if (InstrCount !== 16'd1) begin bad++; $display("FAIL t4_count: %0d want 1", InstrCount); end
        total++; if (PC !== 5'd1) begin bad++; $display("FAIL t4_pc: %0d want 1", PC); end
        total++; if ({Busy, Halted, Error} !== 3'b000) begin bad++; $display("FAIL t4_idle_flags: %b want 000", {Busy, Halted, Error}); end
    endtask

    task automatic test_pc_wrap;
        int n = 0;
        load(0, 16'h1234);
        for (int i = 1; i < DEPTH - 1; i++) load(i, 16'h0080 | 16'(i % 8));
        load(DEPTH - 1, 16'h0040);
        proc_en = 1; lat = 1;
        pulse_start(DEPTH);
        while (InstrCount !== 16'(DEPTH - 1) && n < 400) begin
            @(negedge Clock); n++;
        end
        if (n >= 400) begin total++; bad++; $display("FAIL t5_reach_last: count=%0d want %0d", InstrCount, DEPTH - 1); end
        Stop = 1'b1;
        @(negedge Clock); Stop = 1'b0;
        wait_for(2, 20, "t5_idle");
        total++; if (PC !== 5'd1) begin bad++; $display("FAIL t5_pc: %0d want 1", PC); end
        total++; if (InstrCount !== 16'(DEPTH)) begin bad++; $display("FAIL t5_count: %0d want %0d", InstrCount, DEPTH); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t5_pending: %0d issues missing, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_and_load;
        load(0, 16'h0080); load(1, 16'h0081); load(2, 16'h0082); load(3, 16'h01C0);
        proc_en = 0; Done = 1'b0; busy_cnt = 0;
        pulse_start(1);
        @(negedge Clock);
        LoadEn = 1'b1; LoadAddr = 5'd1; LoadData = 16'h0082;
        @(negedge Clock);
        LoadEn = 1'b0;
        total++; if (PC !== 5'd1) begin bad++; $display("FAIL t6_pc_before_reset: %0d want 1", PC); end
        #2 Reset = 1'b1;
        #1;
        total++; if (PC !== 5'd0) begin bad++; $display("FAIL t6_async_pc: %0d want 0", PC); end
        total++; if (DIN !== 16'h0) begin bad++; $display("FAIL t6_async_din: %h want 0000", DIN); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL t6_async_busy: %b want 0", Busy); end
        @(negedge Clock); Reset = 1'b0;
        @(negedge Clock);
        LoadEn = 1'b1; LoadAddr = 5'd2; LoadData = 16'h01C0; Start = 1'b1;
        tb_mem[2] = 16'h01C0;
        @(negedge Clock);
        LoadEn = 1'b0; Start = 1'b0;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL t6_start_with_load: Busy=%b want 0", Busy); end
        proc_en = 1; lat = 2;
        pulse_start(100);
        wait_for(0, 40, "t6_halt");
        total++; if (InstrCount !== 16'd2) begin bad++; $display("FAIL t6_count: %0d want 2", InstrCount); end
        total++; if (PC !== 5'd2) begin bad++; $display("FAIL t6_pc: %0d want 2", PC); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t6_pending: %0d issues missing, want 0", exp_q.size()); end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stop = 1'b0; LoadEn = 1'b0; Done = 1'b0;
        LoadAddr = '0; LoadData = '0;
        test_reset;
        test_mvi_halt;
        test_add_chain;
        test_timeout;
        test_stop;
        test_pc_wrap;
        test_reset_and_load;
        repeat (4) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
